// File: rtl/demux14_stream_pkg.sv
// demux14_pkg: shared constants and types for the 1-to-4 stream demultiplexer
package demux14_pkg;
    localparam int NCH = 4;
    typedef logic [1:0] ch_sel_t;
    localparam logic EXPLICIT    = 1'b0;
    localparam logic ROUND_ROBIN = 1'b1;
endpackage

// File: rtl/demux14_stream_if.sv
// demux14_stream_if: producer side and four consumer channels of the demultiplexer
interface demux14_stream_if #(parameter int W = 8);
    import demux14_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    ch_sel_t           s;
    logic              mode;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*W-1:0]  out_data;
    modport master (output in_valid, in_data, s, mode, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, s, mode, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/demux14_stream_slot.sv
// demux14_slot: one-entry output register; a load wins over a same-edge drain
module demux14_slot #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         ready
);
    assign ready = ~out_valid | out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux14_stream.sv
// demux14_stream: routes each accepted word to one of four registered channel slots
module demux14_stream
    import demux14_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    demux14_stream_if.slave   bus,
    output ch_sel_t           rr_ptr,
    output logic [CNT_W-1:0]  xfer_cnt
);
    ch_sel_t          dest;
    logic             accept;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   slot_ready;
    logic [NCH-1:0]   slot_valid;
    logic [NCH*W-1:0] slot_data;
    assign dest          = (bus.mode == EXPLICIT) ? bus.s : rr_ptr;
    assign bus.in_ready  = slot_ready[dest];
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    for (genvar k = 0; k < NCH; k++) begin : g_slot
        assign load[k] = accept & (dest == ch_sel_t'(k));
        demux14_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .data      (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_valid (slot_valid[k]),
            .out_data  (slot_data[k*W +: W]),
            .ready     (slot_ready[k])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            xfer_cnt <= '0;
        end else if (accept) begin
            rr_ptr   <= (bus.mode == ROUND_ROBIN) ? rr_ptr + 2'd1 : rr_ptr;
            xfer_cnt <= (&xfer_cnt) ? xfer_cnt : xfer_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_demux14_stream.sv
// tb_demux14_stream: directed stimulus, per-cycle model comparison and per-channel order scoreboard
module tb_demux14_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] rr_ptr;
    logic [3:0] xfer_cnt;
    int         total = 0;
    int         bad = 0;
    logic [3:0] mv;
    logic [7:0] md [4];
    logic [1:0] mrr;
    logic [3:0] mcnt;
    logic [7:0] q [4][$];

    demux14_stream_if #(.W(8)) bus ();
    demux14_stream #(.W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .rr_ptr   (rr_ptr),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: stream rules applied to an abstract slot array plus per-channel word queues
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv = '0;
            mrr = '0;
            mcnt = '0;
            for (int k = 0; k < 4; k++) begin
                md[k] = '0;
                q[k].delete();
            end
        end else begin
            logic [1:0] d;
            logic       acc;
            d = bus.mode ? mrr : bus.s;
            acc = bus.in_valid && (!mv[d] || bus.out_ready[d]);
            for (int k = 0; k < 4; k++)
                if (mv[k] && bus.out_ready[k]) mv[k] = 1'b0;
            if (acc) begin
                mv[d] = 1'b1;
                md[d] = bus.in_data;
                q[d].push_back(bus.in_data);
                if (bus.mode) mrr = mrr + 2'd1;
                if (mcnt != 4'hF) mcnt = mcnt + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0] d;
            d = bus.mode ? mrr : bus.s;
            chk("in_ready", 32'(bus.in_ready), 32'(!mv[d] || bus.out_ready[d]));
            chk("out_valid", 32'(bus.out_valid), 32'(mv));
            chk("out_data", bus.out_data, {md[3], md[2], md[1], md[0]});
            chk("rr_ptr", 32'(rr_ptr), 32'(mrr));
            chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (q[k].size() == 0) chk("drain_unexpected", 32'(k), 32'hFFFF_FFFF);
                    else chk("drain_order", 32'(bus.out_data[k*8 +: 8]), 32'(q[k].pop_front()));
                end
            end
        end
    end

    initial begin
        logic [1:0] rr_seq [6];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.s = '0;
        bus.mode = 1'b0;
        bus.out_ready = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_cnt", 32'(xfer_cnt), 32'h0);
        chk("reset_rr", 32'(rr_ptr), 32'h0);
        chk("reset_data", bus.out_data, 32'h0);

        // 1: explicit select to channel 2
        bus.s = 2'd2;
        bus.in_data = 8'hA5;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t1_valid", 32'(bus.out_valid), 32'h4);
        chk("t1_data", 32'(bus.out_data[23:16]), 32'hA5);
        chk("t1_cnt", 32'(xfer_cnt), 32'h1);

        // 2: blocked on full slot, then same-cycle pass-through refill
        bus.in_data = 8'h3C;
        bus.in_valid = 1'b1;
        #1 chk("t2_blocked", 32'(bus.in_ready), 32'h0);
        step();
        chk("t2_hold", 32'(bus.out_data[23:16]), 32'hA5);
        bus.out_ready = 4'b0100;
        #1 chk("t2_passthru_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = '0;
        chk("t2_valid", 32'(bus.out_valid[2]), 32'h1);
        chk("t2_data", 32'(bus.out_data[23:16]), 32'h3C);
        chk("t2_cnt", 32'(xfer_cnt), 32'h2);

        // 3: round-robin stream with wrap
        bus.mode = 1'b1;
        bus.out_ready = 4'hF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 8'(i + 1);
            step();
            chk("t3_route", 32'(bus.out_data[rr_seq[i]*8 +: 8]), 32'(i + 1));
        end
        bus.in_valid = 1'b0;
        chk("t3_rr_end", 32'(rr_ptr), 32'h2);
        chk("t3_cnt", 32'(xfer_cnt), 32'h8);
        step();

        // 4: head-of-line wait on channel 1
        bus.out_ready = 4'b1101;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = 8'(8'h07 + i);
            step();
        end
        bus.in_data = 8'h0E;
        #1 chk("t4_blocked", 32'(bus.in_ready), 32'h0);
        step();
        chk("t4_rr_hold", 32'(rr_ptr), 32'h1);
        chk("t4_no_skip", 32'(bus.out_data[23:16]), 32'h0B);
        bus.out_ready = 4'hF;
        #1 chk("t4_release", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("t4_resume", 32'(bus.out_data[15:8]), 32'h0E);
        chk("t4_rr_next", 32'(rr_ptr), 32'h2);
        step();

        // 6: fill all slots, then asynchronous reset mid-cycle
        bus.mode = 1'b0;
        bus.out_ready = '0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s = 2'(i);
            bus.in_data = 8'(8'h11 * (i + 1));
            step();
        end
        bus.in_valid = 1'b0;
        chk("t6_full", 32'(bus.out_valid), 32'hF);
        chk("t6_data", bus.out_data, 32'h44332211);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_rr", 32'(rr_ptr), 32'h0);
        chk("t6_rst_cnt", 32'(xfer_cnt), 32'h0);
        step();
        rst_n = 1'b1;

        // 5: saturating counter over 20 words
        bus.mode = 1'b1;
        bus.out_ready = 4'hF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 8'(8'h40 + i);
            step();
            if (i == 13) chk("t5_cnt14", 32'(xfer_cnt), 32'hE);
            if (i == 14) chk("t5_cnt15", 32'(xfer_cnt), 32'hF);
        end
        bus.in_valid = 1'b0;
        chk("t5_sat", 32'(xfer_cnt), 32'hF);
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
